// File: rtl/vram_arbiter.sv
// VRAM owner: display prefetch/scan-out plus round-robin logic ports.
// Display fetches take fixed slots; logic traffic fills the rest.
module vram_arbiter #(
  parameter int H_ACTIVE      = 640,
  parameter int H_TOTAL       = 800,
  parameter int V_ACTIVE      = 480,
  parameter int V_TOTAL       = 525,
  parameter int WORDS_PER_ROW = 40
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        blank,
  output logic [3:0]  pixel_idx,
  input  logic        wr_req,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [12:0] rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        mem_en,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  function automatic logic [12:0] row_base(
    input logic [7:0] r
  );
    logic [12:0] rr;
    rr = {5'd0, r};
    if (WORDS_PER_ROW == 40)
      row_base = (rr << 5) + (rr << 3);
    else
      row_base = rr * 13'(WORDS_PER_ROW);
  endfunction

  logic [9:0]  next_y;
  logic [7:0]  fetch_row;
  logic [5:0]  fetch_col;
  logic        disp_fetch;
  logic [12:0] disp_addr;

  logic        rd_live;
  logic        wr_live;
  logic        grant_rd;
  logic        grant_wr;
  logic        last_wr;

  logic        disp_issue;
  logic        disp_pend;
  logic [15:0] prefetch;
  logic [15:0] shift;
  logic [3:0]  nib;
  logic [15:0] rd_hold;

  // Display slot decode: next span of this line, or col 0 of next line
  always_comb begin
    next_y     = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0
                                               : pixel_y + 10'd1;
    fetch_row  = pixel_y[9:2];
    fetch_col  = '0;
    disp_fetch = 1'b0;
    if (pixel_x == 10'(H_TOTAL - 4)) begin
      fetch_row  = next_y[9:2];
      disp_fetch = (next_y < 10'(V_ACTIVE));
    end else if (pixel_x[3:0] == 4'd12 &&
                 pixel_x < 10'(H_ACTIVE - 16) &&
                 pixel_y < 10'(V_ACTIVE)) begin
      fetch_col  = pixel_x[9:4] + 6'd1;
      disp_fetch = 1'b1;
    end
    disp_addr = row_base(fetch_row) + {7'd0, fetch_col};
  end

  // Logic-port grant; a port in its ack cycle still shows the old request
  always_comb begin
    rd_live  = rd_req & ~rd_ack;
    wr_live  = wr_req & ~wr_ack;
    grant_rd = ~disp_fetch & rd_live & (~wr_live | last_wr);
    grant_wr = ~disp_fetch & wr_live & (~rd_live | ~last_wr);
  end

  // Registered RAM command and logic acks
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      last_wr   <= 1'b1;
    end else begin
      mem_en <= disp_fetch | grant_rd | grant_wr;
      mem_we <= grant_wr;
      wr_ack <= grant_wr;
      rd_ack <= grant_rd;
      unique case (1'b1)
        disp_fetch: mem_addr <= disp_addr;
        grant_wr: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        grant_rd:   mem_addr <= rd_addr;
        default: ;
      endcase
      if (grant_rd | grant_wr)
        last_wr <= grant_wr;
    end
  end

  // Track in-flight reads so returned data lands in the right place
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      disp_issue <= 1'b0;
      disp_pend  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_hold    <= '0;
    end else begin
      disp_issue <= disp_fetch;
      disp_pend  <= disp_issue;
      rd_valid   <= rd_ack;
      if (rd_valid)
        rd_hold <= mem_rdata;
    end
  end

  assign rd_data = rd_valid ? mem_rdata : rd_hold;

  // Nibble for the current 4-pixel group, leftmost in the top bits
  always_comb begin
    unique case (pixel_x[3:2])
      2'd0: nib = shift[15:12];
      2'd1: nib = shift[11:8];
      2'd2: nib = shift[7:4];
      2'd3: nib = shift[3:0];
      default: nib = '0;
    endcase
  end

  // Prefetch capture, span load and registered colour output
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      prefetch  <= '0;
      shift     <= '0;
      pixel_idx <= '0;
    end else begin
      if (disp_pend)
        prefetch <= mem_rdata;
      if (pixel_x[3:0] == 4'd15)
        shift <= prefetch;
      pixel_idx <= blank ? 4'd0 : nib;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural sync RAM.
// Pixel timing is driven by the bench, free-running or pinned.
module tb_vram_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        blank;
  logic [3:0]  pixel_idx;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [12:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic [15:0] ram [0:8191];

  int checks   = 0;
  int failures = 0;
  bit free     = 1'b0;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [15:0] rdv;
  logic [3:0]  exp_pix [0:19];

  vram_arbiter dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .blank     (blank),
    .pixel_idx (pixel_idx),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pos(input logic [9:0] x,
                         input logic [9:0] y);
    pixel_x = x;
    pixel_y = y;
    blank   = (x >= 10'd640) || (y >= 10'd480);
  endtask

  task automatic cyc();
    @(posedge clk_25mhz);
    #1;
    px = pixel_x;
    py = pixel_y;
    if (free) begin
      if (pixel_x == 10'd799)
        set_pos(10'd0,
                (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1);
      else
        set_pos(pixel_x + 10'd1, pixel_y);
    end
  endtask

  task automatic do_write(input logic [12:0] a,
                          input logic [15:0] d);
    bit got;
    got     = 1'b0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (wr_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    chk("wr_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic do_read(input  logic [12:0] a,
                         output logic [15:0] d);
    bit got;
    got     = 1'b0;
    rd_req  = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (rd_ack) got = 1'b1;
    end
    rd_req = 1'b0;
    chk("rd_ack_seen", {31'd0, got}, 32'd1);
    cyc();
    chk("rd_valid", {31'd0, rd_valid}, 32'd1);
    d = rd_data;
  endtask

  initial begin
    exp_pix = '{4'h1, 4'h1, 4'h1, 4'h1,
                4'h2, 4'h2, 4'h2, 4'h2,
                4'h3, 4'h3, 4'h3, 4'h3,
                4'h4, 4'h4, 4'h4, 4'h4,
                4'hA, 4'hA, 4'hA, 4'hA};
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    set_pos(10'd305, 10'd10);

    // power-on reset
    repeat (3) cyc();
    chk("rst_pix", {28'd0, pixel_idx}, 32'd0);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdd", {16'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

    // mid-line reset with a write pending
    wr_req  = 1'b1;
    wr_addr = 13'd7;
    wr_data = 16'h1111;
    cyc();
    chk("pre_rst_ack", {31'd0, wr_ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, wr_ack}, 32'd0);
    chk("arst_en", {31'd0, mem_en}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", {19'd0, mem_addr}, 32'd0);
    chk("arst_wdata", {16'd0, mem_wdata}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("in_rst_ack", {31'd0, wr_ack}, 32'd0);
    end
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ack", {31'd0, wr_ack}, 32'd1);
    chk("post_rst_addr", {19'd0, mem_addr}, 32'd7);
    wr_req = 1'b0;
    cyc();

    // preload in vertical blanking
    set_pos(10'd650, 10'd490);
    do_write(13'd0, 16'h1234);
    do_write(13'd1, 16'hABCD);
    do_write(13'd10, 16'hC0DE);

    // frame wrap fetch, scan-out and display priority
    set_pos(10'd790, 10'd524);
    free    = 1'b1;
    wr_addr = 13'd200;
    wr_data = 16'h0F0F;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (py == 10'd524 && px == 10'd796) begin
        chk("wrap_en", {31'd0, mem_en}, 32'd1);
        chk("wrap_we", {31'd0, mem_we}, 32'd0);
        chk("wrap_addr", {19'd0, mem_addr}, 32'd0);
      end
      if (py == 10'd0 && px < 10'd20)
        chk($sformatf("pix_x%0d", px),
            {28'd0, pixel_idx}, {28'd0, exp_pix[px]});
      if (py == 10'd0 && px == 10'd12) begin
        chk("disp_addr", {19'd0, mem_addr}, 32'd1);
        chk("disp_we", {31'd0, mem_we}, 32'd0);
        chk("disp_noack", {31'd0, wr_ack}, 32'd0);
      end
      if (py == 10'd0 && px == 10'd13) begin
        chk("slot2_ack", {31'd0, wr_ack}, 32'd1);
        chk("slot2_addr", {19'd0, mem_addr}, 32'd200);
        wr_req = 1'b0;
      end
      if (pixel_y == 10'd0 && pixel_x == 10'd12)
        wr_req = 1'b1;
    end
    free   = 1'b0;
    wr_req = 1'b0;

    // line wrap into row 1
    set_pos(10'd796, 10'd3);
    cyc();
    chk("row1_en", {31'd0, mem_en}, 32'd1);
    chk("row1_addr", {19'd0, mem_addr}, 32'd40);

    // past last visible line the slot goes to logic
    set_pos(10'd796, 10'd479);
    wr_req  = 1'b1;
    wr_addr = 13'd300;
    wr_data = 16'h3333;
    cyc();
    chk("end_ack", {31'd0, wr_ack}, 32'd1);
    chk("end_we", {31'd0, mem_we}, 32'd1);
    chk("end_addr", {19'd0, mem_addr}, 32'd300);
    wr_req = 1'b0;
    cyc();

    // round robin: read goes first after a write
    set_pos(10'd650, 10'd490);
    rd_req  = 1'b1;
    rd_addr = 13'd10;
    wr_req  = 1'b1;
    wr_addr = 13'd11;
    wr_data = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rr_rd%0d", i), {31'd0, rd_ack},
          {31'd0, (i % 2 == 0)});
      chk($sformatf("rr_wr%0d", i), {31'd0, wr_ack},
          {31'd0, (i % 2 == 1)});
      chk($sformatf("rr_rv%0d", i), {31'd0, rd_valid},
          {31'd0, (i % 2 == 1)});
      if (i % 2 == 1)
        chk($sformatf("rr_data%0d", i), {16'd0, rd_data},
            32'hC0DE);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    cyc();

    // read after write
    do_write(13'd100, 16'h5A5A);
    do_read(13'd100, rdv);
    chk("raw_data", {16'd0, rdv}, 32'h5A5A);
    cyc();
    chk("raw_rv_drop", {31'd0, rd_valid}, 32'd0);
    chk("raw_hold", {16'd0, rd_data}, 32'h5A5A);
    do_read(13'd11, rdv);
    chk("rr_wdata", {16'd0, rdv}, 32'h7777);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
